aes_inv_cipher: RTL

// AES-128 inverse cipher (FIPS-197 InvCipher); decrypt-side counterpart of the word-serial aes encrypt top.
// Key and ciphertext arrive as 32-bit words over the same start_n/dword_in load protocol the encrypt top uses.
// The block expands the key forward into a 44x32 register file, then runs the rounds in reverse, one column per cycle.

---
 rtl/aes_inv_cipher.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher: word-serial key/ciphertext load, forward key expansion into a 44-word file,
// then column-serial reverse rounds; done rises 94 clk after the last ciphertext word, no backpressure.
package aes_gf_pkg;
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse computed as a^254, which also maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] y;
      y = {x, x} << n;
      return y[15:8];
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
   endfunction
endpackage

// Forward S-box on a 32-bit word (key schedule SubWord).
module s_box (
   input  logic [31:0] din,
   output logic [31:0] dout
);
   import aes_gf_pkg::*;

   always_comb begin
      dout = '0;
      for (int b = 0; b < 4; b++)
         dout[8*b +: 8] = affine_fwd(gf_inv(din[8*b +: 8]));
   end
endmodule

// Inverse S-box on a 32-bit word (one state row per instance).
module inv_s_box (
   input  logic [31:0] din,
   output logic [31:0] dout
);
   import aes_gf_pkg::*;

   always_comb begin
      dout = '0;
      for (int b = 0; b < 4; b++)
         dout[8*b +: 8] = gf_inv(affine_inv(din[8*b +: 8]));
   end
endmodule

module aes_inv_cipher #(
   parameter logic [31:0] OUT_IDLE      = 32'h0,
   parameter bit          CLEAR_ON_READ = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start_n,
   input  logic         start_read_n,
   input  logic [31:0]  dword_in,
   output logic [31:0]  dword_out,
   output logic         done,
   output logic         busy,
   output logic [127:0] dbg_state
);
   import aes_gf_pkg::*;

   typedef enum logic [3:0] {
      IDLE, LOAD_KEY, LOAD_CT, KEXP, ARK0, RSUB, RCOL, FSUB, FARK, DONE, READ
   } fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [1:0]   col;
   logic [3:0]   rnd;
   logic [5:0]   kidx;
   logic [127:0] st;
   logic [127:0] sub_out;
   logic [31:0]  w [0:43];
   logic [31:0]  cur_col, rk_word, kexp_prev, kexp_t, rot_sub;
   logic [5:0]   rk_idx;
   logic         last_col;

   function automatic logic [31:0] inv_mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      logic [7:0] r;
      case (n)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Column c lives at bits [127-32c -: 32]; 3-c is simply ~c for a 2-bit counter.
   assign last_col  = (col == 2'd3);
   assign cur_col   = st[{~col, 5'd0} +: 32];
   assign dbg_state = st;

   always_comb begin
      case (fsm)
         ARK0:    rk_idx = {4'd10, col};
         FARK:    rk_idx = {4'd0, col};
         default: rk_idx = {rnd, col};
      endcase
   end

   assign rk_word = w[rk_idx];

   assign kexp_prev = w[kidx - 6'd1];

   s_box u_sbox (
      .din  ({kexp_prev[23:0], kexp_prev[31:24]}),
      .dout (rot_sub)
   );

   assign kexp_t = (kidx[1:0] == 2'b00) ? (rot_sub ^ {rcon(kidx[5:2]), 24'h0}) : kexp_prev;

   // InvShiftRows folded into the row gather: row r output column c takes input column c-r.
   for (genvar r = 0; r < 4; r++) begin : g_row
      logic [31:0] row_in, row_out;
      for (genvar c = 0; c < 4; c++) begin : g_byte
         localparam int SRC = (c - r + 4) % 4;
         assign row_in[31-8*c -: 8]            = st[127-32*SRC-8*r -: 8];
         assign sub_out[127-32*c-8*r -: 8]     = row_out[31-8*c -: 8];
      end
      inv_s_box u_isb (
         .din  (row_in),
         .dout (row_out)
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) fsm <= IDLE;
      else          fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt   = fsm;
      done      = 1'b0;
      busy      = 1'b1;
      dword_out = OUT_IDLE;
      case (fsm)
         IDLE: begin
            busy = 1'b0;
            if (!start_n) fsm_nxt = LOAD_KEY;
         end
         LOAD_KEY: if (last_col) fsm_nxt = LOAD_CT;
         LOAD_CT:  if (last_col) fsm_nxt = KEXP;
         KEXP:     if (kidx == 6'd43) fsm_nxt = ARK0;
         ARK0:     if (last_col) fsm_nxt = RSUB;
         RSUB:     fsm_nxt = RCOL;
         RCOL:     if (last_col) fsm_nxt = (rnd >= 4'd2) ? RSUB : FSUB;
         FSUB:     fsm_nxt = FARK;
         FARK:     if (last_col) fsm_nxt = DONE;
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (!start_read_n) fsm_nxt = READ;
         end
         READ: begin
            done      = 1'b1;
            dword_out = cur_col;
            if (last_col) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col  <= 2'd0;
         rnd  <= 4'd0;
         kidx <= 6'd0;
         st   <= '0;
      end else begin
         case (fsm)
            LOAD_KEY, LOAD_CT, ARK0, RCOL, FARK, READ: col <= col + 2'd1;
            default:                                    col <= 2'd0;
         endcase

         case (fsm)
            LOAD_CT: kidx <= 6'd4;
            KEXP:    kidx <= kidx + 6'd1;
            default: kidx <= 6'd0;
         endcase

         if (fsm == ARK0)                 rnd <= 4'd9;
         else if (fsm == RCOL && last_col) rnd <= rnd - 4'd1;

         case (fsm)
            LOAD_CT:    st[{~col, 5'd0} +: 32] <= dword_in;
            ARK0, FARK: st[{~col, 5'd0} +: 32] <= cur_col ^ rk_word;
            RCOL:       st[{~col, 5'd0} +: 32] <= inv_mix(cur_col ^ rk_word);
            RSUB, FSUB: st <= sub_out;
            READ:       if (last_col && CLEAR_ON_READ) st <= '0;
            default:    st <= st;
         endcase
      end
   end

   // Key words are not reset; they are only meaningful after a fresh load anyway.
   always_ff @(posedge clk) begin
      if (fsm == LOAD_KEY)
         w[{4'd0, col}] <= dword_in;
      else if (fsm == KEXP)
         w[kidx] <= w[kidx - 6'd4] ^ kexp_t;
      else if (fsm == READ && last_col && CLEAR_ON_READ)
         for (int i = 0; i < 44; i++) w[i] <= '0;
   end
endmodule
